// File: rtl/cp0_reg_pkg.sv
// ---------------------------------------------------------------------------
// Module : cp0_reg_pkg
// Brief  : CPU-wide CP0 defines: register numbers, ExcCodes, bit positions,
//          and the exception flag bundle carried down the pipeline.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cp0_reg_pkg;

  localparam logic [4:0] c_reg_badvaddr = 5'd8;
  localparam logic [4:0] c_reg_count    = 5'd9;
  localparam logic [4:0] c_reg_compare  = 5'd11;
  localparam logic [4:0] c_reg_status   = 5'd12;
  localparam logic [4:0] c_reg_cause    = 5'd13;
  localparam logic [4:0] c_reg_epc      = 5'd14;

  localparam logic [4:0] c_exc_int  = 5'h00;
  localparam logic [4:0] c_exc_adel = 5'h04;
  localparam logic [4:0] c_exc_ades = 5'h05;
  localparam logic [4:0] c_exc_sys  = 5'h08;
  localparam logic [4:0] c_exc_bp   = 5'h09;
  localparam logic [4:0] c_exc_ri   = 5'h0A;
  localparam logic [4:0] c_exc_ov   = 5'h0C;

  localparam int c_status_ie  = 0;
  localparam int c_status_exl = 1;
  localparam int c_status_bev = 22;
  localparam int c_cause_ti   = 30;
  localparam int c_cause_bd   = 31;

  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic ReservedInstruction;
    logic Overflow;
    logic Syscall;
    logic Break;
    logic Eret;
    logic WrWrongAddressinMEM;
    logic RdWrongAddressinMEM;
  } ExceptinPipeType;

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ---------------------------------------------------------------------------
// Module : cp0_timer
// Brief  : Count/Compare timer with clock divider and sticky timer interrupt.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(COUNT_DIV - 1);
  localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic [31:0]      r_count;
  logic [31:0]      r_compare;
  logic             r_ti;
  logic             w_tick;

  assign w_tick = (r_div == c_div_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + c_div_one;
      if (i_count_we)
        r_count <= i_wr_data;
      else if (w_tick)
        r_count <= r_count + 32'd1;
      if (i_compare_we)
        r_compare <= i_wr_data;
      // Writing Compare acknowledges the timer interrupt, even on a match edge
      if (i_compare_we)
        r_ti <= 1'b0;
      else if (r_count == r_compare)
        r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_reg.sv
// ---------------------------------------------------------------------------
// Module : cp0_reg
// Brief  : CP0 register file: MTC0/MFC0, exception/ERET commit and redirect,
//          interrupt request generation.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
  parameter int          COUNT_DIV = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WB_CP0Wr_MTC0,
  input  logic [4:0]      WB_Dst,
  input  logic [31:0]     WB_Result,
  input  ExceptinPipeType WB_ExceptType,
  input  logic [31:0]     WB_PC,
  input  logic            WB_IsInDelaySlot,
  input  logic [31:0]     WB_ALUOut,
  input  logic [5:0]      Ext_Int,
  input  logic [4:0]      EXE_CP0_RdAddr,
  output logic [31:0]     CP0_RdData,
  output logic [31:0]     CP0_Status,
  output logic [31:0]     CP0_Cause,
  output logic [31:0]     CP0_EPC,
  output logic            CP0_Interrupt,
  output logic            CP0_Redirect,
  output logic [31:0]     CP0_RedirectPC
);

  logic [31:0] r_badvaddr;
  logic [31:0] r_epc;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic        w_mtc0_we;
  logic        w_exc;
  logic        w_eret;
  logic [4:0]  w_exc_code;
  logic        w_badv_we;
  logic [31:0] w_badv_val;
  logic        w_byp;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_status_wv;
  logic [31:0] w_cause_wv;

  // Any flag, ERET included, squashes the MTC0 of the same instruction
  assign w_mtc0_we = WB_CP0Wr_MTC0 & ~(|WB_ExceptType);

  always_comb begin
    w_exc      = 1'b1;
    w_exc_code = c_exc_int;
    w_badv_we  = 1'b0;
    w_badv_val = WB_PC;
    if (WB_ExceptType.Interrupt) begin
      w_exc_code = c_exc_int;
    end else if (WB_ExceptType.WrongAddressinIF) begin
      w_exc_code = c_exc_adel;
      w_badv_we  = 1'b1;
    end else if (WB_ExceptType.ReservedInstruction) begin
      w_exc_code = c_exc_ri;
    end else if (WB_ExceptType.Overflow) begin
      w_exc_code = c_exc_ov;
    end else if (WB_ExceptType.Syscall) begin
      w_exc_code = c_exc_sys;
    end else if (WB_ExceptType.Break) begin
      w_exc_code = c_exc_bp;
    end else if (WB_ExceptType.RdWrongAddressinMEM) begin
      w_exc_code = c_exc_adel;
      w_badv_we  = 1'b1;
      w_badv_val = WB_ALUOut;
    end else if (WB_ExceptType.WrWrongAddressinMEM) begin
      w_exc_code = c_exc_ades;
      w_badv_we  = 1'b1;
      w_badv_val = WB_ALUOut;
    end else begin
      w_exc = 1'b0;
    end
  end

  assign w_eret         = ~w_exc & WB_ExceptType.Eret;
  assign CP0_Redirect   = w_exc | w_eret;
  assign CP0_RedirectPC = w_exc ? EXC_ENTRY : r_epc;

  assign w_status    = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause     = {r_bd, w_ti, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exc_code, 2'b0};
  assign w_status_wv = {9'b0, 1'b1, 6'b0, WB_Result[15:8], 6'b0, WB_Result[1:0]};
  assign w_cause_wv  = {r_bd, w_ti, 14'b0, r_ip_hw, WB_Result[9:8], 1'b0, r_exc_code, 2'b0};
  assign w_byp       = w_mtc0_we && (WB_Dst == EXE_CP0_RdAddr);

  always_comb begin
    CP0_RdData = 32'b0;
    case (EXE_CP0_RdAddr)
      c_reg_badvaddr: CP0_RdData = r_badvaddr;
      c_reg_count:    CP0_RdData = w_byp ? WB_Result : w_count;
      c_reg_compare:  CP0_RdData = w_byp ? WB_Result : w_compare;
      c_reg_status:   CP0_RdData = w_byp ? w_status_wv : w_status;
      c_reg_cause:    CP0_RdData = w_byp ? w_cause_wv : w_cause;
      c_reg_epc:      CP0_RdData = w_byp ? WB_Result : r_epc;
      default:        CP0_RdData = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_badvaddr <= '0;
      r_epc      <= '0;
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exc_code <= '0;
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
    end else begin
      r_ip_hw <= {Ext_Int[5] | w_ti, Ext_Int[4:0]};
      if (w_mtc0_we) begin
        case (WB_Dst)
          c_reg_status: begin
            r_im  <= WB_Result[15:8];
            r_exl <= WB_Result[c_status_exl];
            r_ie  <= WB_Result[c_status_ie];
          end
          c_reg_cause: r_ip_sw <= WB_Result[9:8];
          c_reg_epc:   r_epc   <= WB_Result;
          default: ;
        endcase
      end
      // Exception updates come last so they win over any field written above
      if (w_exc) begin
        r_exc_code <= w_exc_code;
        r_exl      <= 1'b1;
        if (!r_exl) begin
          r_epc <= WB_IsInDelaySlot ? WB_PC - 32'd4 : WB_PC;
          r_bd  <= WB_IsInDelaySlot;
        end
        if (w_badv_we)
          r_badvaddr <= w_badv_val;
      end else if (w_eret) begin
        r_exl <= 1'b0;
      end
    end
  end

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_count_we   (w_mtc0_we && (WB_Dst == c_reg_count)),
    .i_compare_we (w_mtc0_we && (WB_Dst == c_reg_compare)),
    .i_wr_data    (WB_Result),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  assign CP0_Status    = w_status;
  assign CP0_Cause     = w_cause;
  assign CP0_EPC       = r_epc;
  assign CP0_Interrupt = (|({r_ip_hw, r_ip_sw} & r_im)) & r_ie & ~r_exl;

endmodule

`default_nettype wire
